quota_stream_ctrl: RTL

//   Sequencer for the stochastic-computing quota datapath. Accepts one signed

---
 rtl/quota_stream_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/quota_stream_ctrl.sv
// Converts one signed quantised operand per handshake into a BITSTREAM-beat stochastic bitstream.
// Build option QUOTA_BITREV_EN: compare the bit-reversed beat count (spread ones) instead of a thermometer.
module quota_stream_ctrl #(
  parameter int unsigned BITSTREAM = 64,
  parameter int unsigned QUANT     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [QUANT-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_bit,
  output logic                         out_first,
  output logic                         out_last,
  output logic [$clog2(BITSTREAM):0]   quota,
  output logic                         busy
);

  localparam int unsigned CntW    = $clog2(BITSTREAM);
  localparam int unsigned Shift   = QUANT - CntW;
  localparam int unsigned RoundSh = (Shift > 0) ? Shift - 1 : 0;
  localparam logic [QUANT:0]   RoundInc = (QUANT + 1)'(1) << RoundSh;
  localparam logic [CntW-1:0]  LastCnt  = CntW'(BITSTREAM - 1);

  if ((BITSTREAM < 2) || ((BITSTREAM & (BITSTREAM - 1)) != 0)) begin : g_bad_bitstream
    $error("BITSTREAM must be a power of two");
  end
  if (QUANT <= CntW) begin : g_bad_quant
    $error("QUANT must exceed clog2(BITSTREAM)");
  end

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntW:0]     quota_q;
  logic              out_valid_q, out_bit_q, out_first_q, out_last_q, busy_q;

  // Flipping the sign bit biases the two's-complement operand to 0..2^QUANT-1.
  logic [QUANT:0]    off, rounded;
  logic [CntW:0]     quota_calc;
  logic [CntW-1:0]   cnt_inc;
  logic              beat_acc, last_beat;

  assign off        = {1'b0, ~in_data[QUANT-1], in_data[QUANT-2:0]};
  assign rounded    = off + RoundInc;
  assign quota_calc = (CntW + 1)'(rounded >> Shift);
  assign cnt_inc    = cnt_q + 1'b1;
  assign last_beat  = (cnt_q == LastCnt);
  assign beat_acc   = out_valid_q && out_ready;

  assign in_ready  = (state_q == StIdle) || (last_beat && out_ready);
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign quota     = quota_q;
  assign busy      = busy_q;

  function automatic logic beat_bit(input logic [CntW-1:0] c, input logic [CntW:0] q);
    logic [CntW-1:0] cmp;
`ifdef QUOTA_BITREV_EN
    for (int i = 0; i < int'(CntW); i++) begin
      cmp[i] = c[CntW-1-i];
    end
`else
    cmp = c;
`endif
    return ({1'b0, cmp} < q);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      quota_q     <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else if (clr) begin
      // Abort drops the partial stream; quota_q intentionally keeps its value.
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q     <= StStream;
            quota_q     <= quota_calc;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            out_bit_q   <= beat_bit('0, quota_calc);
            out_first_q <= 1'b1;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        StStream: begin
          if (beat_acc) begin
            if (last_beat) begin
              if (in_valid) begin
                quota_q     <= quota_calc;
                cnt_q       <= '0;
                out_bit_q   <= beat_bit('0, quota_calc);
                out_first_q <= 1'b1;
                out_last_q  <= 1'b0;
              end else begin
                state_q     <= StIdle;
                cnt_q       <= '0;
                out_valid_q <= 1'b0;
                out_bit_q   <= 1'b0;
                out_first_q <= 1'b0;
                out_last_q  <= 1'b0;
                busy_q      <= 1'b0;
              end
            end else begin
              cnt_q       <= cnt_inc;
              out_bit_q   <= beat_bit(cnt_inc, quota_q);
              out_first_q <= 1'b0;
              out_last_q  <= (cnt_inc == LastCnt);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
